// File: rtl/rtc_pkg.sv
// Shared encodings and default sizing for the RTC burst sequencer.
package rtc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    MODE_READ  = 1'b0,
    MODE_WRITE = 1'b1
  } mode_e;

  localparam int N_REGS_DEF       = 7;
  localparam int CYC_PER_XFER_DEF = 34;

endpackage

// File: rtl/rtc_xfer_counter.sv
// Per-register cycle timer plus register index; last flags the final cycle of the burst.
module rtc_xfer_counter
  import rtc_pkg::*;
#(
  parameter int N_REGS       = N_REGS_DEF,
  parameter int CYC_PER_XFER = CYC_PER_XFER_DEF,
  parameter int IDX_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [7:0]       timer_q, timer_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slot_end;
  logic             idx_end;

  assign slot_end = (timer_q == 8'(CYC_PER_XFER - 1));
  assign idx_end  = (idx_q == IDX_W'(N_REGS - 1));
  assign last     = slot_end && idx_end;
  assign idx      = idx_q;

  always_comb begin
    timer_d = timer_q;
    idx_d   = idx_q;
    if (clr) begin
      timer_d = '0;
      idx_d   = '0;
    end else if (en) begin
      if (slot_end) begin
        timer_d = '0;
        // At the final slot the index folds back to 0 so IDLE/DONE see a clean value.
        idx_d   = idx_end ? '0 : idx_q + 1'b1;
      end else begin
        timer_d = timer_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_q <= '0;
      idx_q   <= '0;
    end else begin
      timer_q <= timer_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: rtl/rtc_burst_seq.sv
// Sequences a burst of RTC register transfers and steers the RAM/RTC datapath
// from the bus-cycle engine's phase flags.
module rtc_burst_seq
  import rtc_pkg::*;
#(
  parameter int N_REGS       = N_REGS_DEF,
  parameter int CYC_PER_XFER = CYC_PER_XFER_DEF,
  parameter int IDX_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             bus_do_it,
  output logic             bus_w_r,
  input  logic             bus_send_add,
  input  logic             bus_send_data,
  input  logic             bus_read_data,
  output logic [IDX_W-1:0] ram_idx,
  output logic             ram_sel_addr,
  output logic             rtc_to_ram,
  output logic             ram_to_rtc,
  output logic             w_ram_enable,
  output logic             r_ram_enable,
  output state_e           dbg_state
);

  state_e state_q;
  mode_e  mode_q;
  logic   busy_q, done_q, do_it_q, w_r_q;
  logic   cnt_clr, cnt_en, cnt_last;

  // Valid/ready: start is a one-cycle request accepted only in IDLE; done is a
  // one-cycle completion pulse with no back-pressure.
  assign cnt_en  = (state_q == ST_XFER);
  assign cnt_clr = (state_q != ST_XFER) || abort;

  rtc_xfer_counter #(
    .N_REGS       (N_REGS),
    .CYC_PER_XFER (CYC_PER_XFER),
    .IDX_W        (IDX_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .idx   (ram_idx),
    .last  (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_READ;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      do_it_q <= 1'b0;
      w_r_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_XFER;
            mode_q  <= mode_e'(mode);
            busy_q  <= 1'b1;
            do_it_q <= 1'b1;
            w_r_q   <= mode;
          end
        end
        ST_XFER: begin
          // abort outranks the terminal count so an aborted burst never pulses done.
          if (abort || cnt_last) begin
            state_q <= abort ? ST_IDLE : ST_DONE;
            done_q  <= !abort;
            busy_q  <= 1'b0;
            do_it_q <= 1'b0;
            w_r_q   <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign bus_do_it = do_it_q;
  assign bus_w_r   = w_r_q;
  assign dbg_state = state_q;

  always_comb begin
    ram_sel_addr = 1'b0;
    rtc_to_ram   = 1'b0;
    ram_to_rtc   = 1'b0;
    w_ram_enable = 1'b0;
    r_ram_enable = 1'b0;
    if (state_q == ST_XFER) begin
      case ({bus_send_add, bus_send_data, bus_read_data})
        3'b100: begin
          ram_sel_addr = 1'b1;
          r_ram_enable = 1'b1;
          ram_to_rtc   = 1'b1;
        end
        3'b010: begin
          r_ram_enable = (mode_q == MODE_WRITE);
          ram_to_rtc   = (mode_q == MODE_WRITE);
        end
        3'b001: begin
          w_ram_enable = (mode_q == MODE_READ);
          rtc_to_ram   = (mode_q == MODE_READ);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_burst_seq.sv
// Directed bench for rtc_burst_seq: default-size instance for read/abort/reset
// scenarios and a small write-mode instance.
module tb_rtc_burst_seq;
  import rtc_pkg::*;

  localparam int NA = 7;
  localparam int CA = 34;
  localparam int NB = 3;
  localparam int CB = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_start, a_mode, a_abort, a_add, a_data, a_rd;
  logic       a_busy, a_done, a_do_it, a_w_r, a_sel, a_r2r, a_m2r, a_w_en, a_r_en;
  logic [3:0] a_idx;
  state_e     a_state;

  logic       b_reset, b_start, b_mode, b_abort, b_add, b_data, b_rd;
  logic       b_busy, b_done, b_do_it, b_w_r, b_sel, b_r2r, b_m2r, b_w_en, b_r_en;
  logic [3:0] b_idx;
  state_e     b_state;

  int n_assert = 0;
  int n_fail   = 0;
  int groups;
  logic [3:0] exp_q[$];

  rtc_burst_seq dut_a (
    .clk(clk), .reset(a_reset), .start(a_start), .mode(a_mode), .abort(a_abort),
    .busy(a_busy), .done(a_done), .bus_do_it(a_do_it), .bus_w_r(a_w_r),
    .bus_send_add(a_add), .bus_send_data(a_data), .bus_read_data(a_rd),
    .ram_idx(a_idx), .ram_sel_addr(a_sel), .rtc_to_ram(a_r2r), .ram_to_rtc(a_m2r),
    .w_ram_enable(a_w_en), .r_ram_enable(a_r_en), .dbg_state(a_state)
  );

  rtc_burst_seq #(.N_REGS(NB), .CYC_PER_XFER(CB), .IDX_W(4)) dut_b (
    .clk(clk), .reset(b_reset), .start(b_start), .mode(b_mode), .abort(b_abort),
    .busy(b_busy), .done(b_done), .bus_do_it(b_do_it), .bus_w_r(b_w_r),
    .bus_send_add(b_add), .bus_send_data(b_data), .bus_read_data(b_rd),
    .ram_idx(b_idx), .ram_sel_addr(b_sel), .rtc_to_ram(b_r2r), .ram_to_rtc(b_m2r),
    .w_ram_enable(b_w_en), .r_ram_enable(b_r_en), .dbg_state(b_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a_quiet(input string tag);
    check(tag, {a_busy, a_done, a_do_it, a_w_r, a_sel, a_r2r, a_m2r, a_w_en, a_r_en, a_idx}, 0);
  endtask

  // One burst on dut_a; abort_k/rst_k/conflict_k = 0 disables that event.
  task automatic burst_a(input logic md, input int abort_k, input int rst_k,
                         input int conflict_k, input bit restart);
    int   total, term, t;
    bit   cut;
    logic act, add, rd, dat, ea, er, ewd, ew_prev, prev_w, exp_done;
    total = NA * CA;
    term  = total;
    cut   = 1'b0;
    if (abort_k > 0) begin term = abort_k; cut = 1'b1; end
    if (rst_k > 0)   begin term = rst_k;   cut = 1'b1; end
    @(posedge clk); #1;
    a_start = 1'b1; a_mode = md; a_abort = 1'b0;
    a_add = 1'b0; a_data = 1'b0; a_rd = 1'b0;
    @(negedge clk);
    check("busy_before_start", a_busy, 0);
    ew_prev = 1'b0; prev_w = 1'b0; groups = 0;
    for (int k = 1; k <= total + 3; k++) begin
      t = (k - 1) % CA;
      @(posedge clk); #1;
      a_start = (restart && (k == 3 || k == total + 1)) || (k == rst_k);
      a_mode  = ~md;
      a_abort = (k == abort_k);
      a_reset = !(k == rst_k);
      add = (t >= 2 && t <= 5) || (k == conflict_k);
      rd  = !md && (t >= 10 && t <= 13);
      dat = md && (t >= 10 && t <= 13);
      a_add = add; a_rd = rd; a_data = dat;
      act = (k <= term);
      ea  = act && add && !rd && !dat;
      er  = act && rd && !add && !dat && !md;
      ewd = act && dat && !add && !rd && md;
      exp_done = !cut && (k == total + 1);
      if (er && !ew_prev) exp_q.push_back(4'((k - 1) / CA));
      ew_prev = er;
      @(negedge clk);
      check("busy", a_busy, act);
      check("done", a_done, exp_done);
      check("bus_do_it", a_do_it, act);
      check("bus_w_r", a_w_r, act && md);
      check("ram_idx", a_idx, act ? (k - 1) / CA : 0);
      check("state", a_state, act ? ST_XFER : (exp_done ? ST_DONE : ST_IDLE));
      check("steer", {a_sel, a_r_en, a_m2r, a_w_en, a_r2r}, {ea, ea || ewd, ea || ewd, er, er});
      if (a_w_en && !prev_w) begin
        groups++;
        check("group_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("group_idx", a_idx, exp_q.pop_front());
      end
      prev_w = a_w_en;
    end
    a_start = 1'b0; a_abort = 1'b0; a_reset = 1'b1;
    a_add = 1'b0; a_data = 1'b0; a_rd = 1'b0;
    check("exp_q_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic add, dat;
    int   t, r_cycles;
    a_reset = 1'b0; a_start = 1'b0; a_mode = 1'b1; a_abort = 1'b0;
    a_add = 1'b0; a_data = 1'b0; a_rd = 1'b0;
    b_reset = 1'b0; b_start = 1'b0; b_mode = 1'b0; b_abort = 1'b0;
    b_add = 1'b0; b_data = 1'b0; b_rd = 1'b0;

    // Reset, with start held high to show it is ignored while reset=0.
    @(posedge clk); #1; a_start = 1'b1; b_start = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_a_quiet("reset_a_outputs");
    check("reset_a_state", a_state, ST_IDLE);
    check("reset_b_outputs", {b_busy, b_done, b_do_it, b_w_r, b_sel, b_r_en, b_w_en, b_idx}, 0);
    @(posedge clk); #1; a_start = 1'b0; b_start = 1'b0; a_reset = 1'b1; b_reset = 1'b1;
    @(negedge clk);
    check_a_quiet("idle_after_reset");

    // Abort while idle has no effect.
    @(posedge clk); #1; a_abort = 1'b1;
    @(negedge clk); check("abort_idle_busy", a_busy, 0);
    @(posedge clk); #1; a_abort = 1'b0;
    @(negedge clk); check("abort_idle_state", a_state, ST_IDLE);

    burst_a(1'b0, 0, 0, 0, 1'b0);
    check("read_groups", groups, NA);
    burst_a(1'b0, 50, 0, 0, 1'b0);
    burst_a(1'b0, 0, 100, 0, 1'b0);
    burst_a(1'b0, 0, 0, 45, 1'b1);
    check("restart_read_groups", groups, NA);
    burst_a(1'b0, NA * CA, 0, 0, 1'b0);
    burst_a(1'b1, 0, 0, 0, 1'b0);
    check("write_groups", groups, 0);

    // Small write burst: address at slot cycles 1..2, data at 5..6.
    @(posedge clk); #1; b_start = 1'b1; b_mode = 1'b1;
    r_cycles = 0;
    for (int k = 1; k <= NB * CB + 3; k++) begin
      t = (k - 1) % CB;
      @(posedge clk); #1;
      b_start = 1'b0; b_mode = 1'b0;
      add = (t == 1 || t == 2);
      dat = (t == 5 || t == 6);
      b_add = add; b_data = dat; b_rd = 1'b0;
      @(negedge clk);
      check("b_busy", b_busy, k <= NB * CB);
      check("b_bus_w_r", b_w_r, k <= NB * CB);
      check("b_r_en", b_r_en, (k <= NB * CB) && (add || dat));
      check("b_sel", b_sel, (k <= NB * CB) && add);
      check("b_w_en", {b_w_en, b_r2r}, 0);
      check("b_done", b_done, k == NB * CB + 1);
      check("b_idx", b_idx, (k <= NB * CB) ? (k - 1) / CB : 0);
      if (b_r_en) r_cycles++;
    end
    check("b_r_en_cycles", r_cycles, NB * 4);
    b_add = 1'b0; b_data = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/rtc_burst_seq.md
RTC_BURST_SEQ -- requirements
Module: rtc_burst_seq

Interface
REQ-001 Parameter N_REGS, default 7: number of RTC registers moved per burst, range 1..16.
REQ-002 Parameter CYC_PER_XFER, default 34: clock cycles allotted to one register transfer, range 8..255.
REQ-003 Parameter IDX_W, default 4: width of the register index, at least clog2(N_REGS).
REQ-004 Port clk, input, 1: the single system clock, rising edge active.
REQ-005 Port reset, input, 1: synchronous, active-low reset.
REQ-006 Port start, input, 1: single-cycle request to begin a burst.
REQ-007 Port mode, input, 1: burst direction, 0 = read (RTC->RAM), 1 = write (RAM->RTC); sampled with start.
REQ-008 Port abort, input, 1: terminates the burst in progress.
REQ-009 Port busy, output, 1: high while a burst is in progress.
REQ-010 Port done, output, 1: one-cycle pulse when a burst completes normally.
REQ-011 Port bus_do_it / bus_w_r, output, 1 each: request and direction to the RTC bus-cycle engine.
REQ-012 Port bus_send_add / bus_send_data / bus_read_data, input, 1 each: phase flags returned by the bus-cycle engine.
REQ-013 Port ram_idx, output, IDX_W: index of the register currently being transferred.
REQ-014 Port ram_sel_addr, output, 1: 1 selects the RAM slot holding the RTC address, 0 selects the data slot.
REQ-015 Port rtc_to_ram / ram_to_rtc / w_ram_enable / r_ram_enable, output, 1 each: datapath steering and RAM strobes.

Function
REQ-016 States: IDLE, XFER, DONE.
REQ-017 IDLE -> XFER on start=1; mode is latched into an internal mode register on the same edge.
REQ-018 start is ignored in XFER and DONE; mode changes after the start edge have no effect.
REQ-019 XFER: a timer runs 0..CYC_PER_XFER-1 and ram_idx starts at 0.
REQ-020 XFER, timer = CYC_PER_XFER-1: if ram_idx < N_REGS-1, ram_idx increments and the timer returns to 0; otherwise the state goes to DONE.
REQ-021 XFER lasts exactly N_REGS*CYC_PER_XFER cycles.
REQ-022 DONE lasts one cycle with done=1, then the state goes to IDLE.
REQ-023 busy = 1 exactly while the state is XFER.
REQ-024 XFER: bus_do_it = 1 and bus_w_r = the latched mode; IDLE and DONE: both are 0.
REQ-025 Address phase (bus_send_add only): ram_sel_addr=1, r_ram_enable=1, ram_to_rtc=1, all other steering outputs 0.
REQ-026 Read data phase (latched mode=0, bus_read_data only): ram_sel_addr=0, w_ram_enable=1, rtc_to_ram=1, all other steering outputs 0.
REQ-027 Write data phase (latched mode=1, bus_send_data only): ram_sel_addr=0, r_ram_enable=1, ram_to_rtc=1, all other steering outputs 0.
REQ-028 Steering outputs are 0 in all other cases: multiple flags high, a flag that does not match the mode, or any state other than XFER.
REQ-029 Steering outputs are combinational from the state and the bus flags, with zero-cycle latency.
REQ-030 abort=1 in XFER: the state goes to IDLE on the next edge with no done pulse; the timer and ram_idx clear.
REQ-031 abort is ignored in IDLE and DONE.
REQ-032 abort and the terminal timer count in the same cycle: abort wins and no done pulse is issued.

Reset
REQ-033 reset=0 at a clock edge forces IDLE with timer=0, ram_idx=0 and latched mode=0.
REQ-034 After reset, busy, done, bus_do_it, bus_w_r and all steering outputs are 0.
REQ-035 Reset mid-burst behaves as abort and takes priority over it; start is ignored while reset=0.

Structure
REQ-036 State encoding, mode encoding and the default values of N_REGS and CYC_PER_XFER live in the shared package rtc_pkg.
REQ-037 The timer and index pair is one sub-module, rtc_xfer_counter, with inputs clr, en and wrap output last.

Verification
REQ-038 Read burst, defaults, bus model asserting send_add then read_data each slot: busy for 238 cycles, 7 w_ram_enable pulse groups with ram_idx 0..6, done at cycle 239.
REQ-039 Write burst, N_REGS=3, CYC_PER_XFER=10: bus_w_r=1 for 30 cycles; r_ram_enable during both phases; w_ram_enable never asserted.
REQ-040 abort at cycle 50 of a default burst: busy=0 at cycle 51, no done pulse, ram_idx=0.
REQ-041 reset=0 at cycle 100 of a burst: all outputs 0 on the next edge; a new start afterwards runs a full 238-cycle burst.
REQ-042 start re-pulsed during XFER and during DONE, plus bus_send_add and bus_read_data high together: no restart, and all steering outputs 0 in the conflict cycle.
